// File: rtl/uart_tx_ctrl.sv
// uart_tx_ctrl: frame sequencer for the UART transmitter.
// Issues the load strobe to the serializer / parity_calc, then walks
// START -> DATA (LSB first) -> optional PARITY -> STOP, one bit per CLK.
// Build option: define UART_TX_TWO_STOP_EN to append a second stop bit (STOP2).
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | line high, waiting for Data_Valid
// START  | start bit on the line (mux_sel 01)
// DATA   | data bit bit_cnt on the line, serializer shifting (mux_sel 10)
// PARITY | parity bit on the line (mux_sel 11), only when par_en_q
// STOP   | stop bit (mux_sel 00); final stop state in single-stop builds
// STOP2  | second stop bit (mux_sel 00), UART_TX_TWO_STOP_EN builds only
module uart_tx_ctrl #(
    parameter int DATA_LENGTH = 8
) (
    input  logic                           CLK,
    input  logic                           RST,
    input  logic                           Data_Valid,
    input  logic                           PAR_EN,
    output logic                           load,
    output logic                           ser_en,
    output logic [1:0]                     mux_sel,
    output logic [$clog2(DATA_LENGTH)-1:0] bit_cnt,
    output logic                           busy
);

    localparam int CNT_W = $clog2(DATA_LENGTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_LENGTH - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
`ifdef UART_TX_TWO_STOP_EN
        STOP   = 3'd4,
        STOP2  = 3'd5
`else
        STOP   = 3'd4
`endif
    } state_t;

    // The stop state that can accept a back-to-back request.
`ifdef UART_TX_TWO_STOP_EN
    localparam state_t FINAL_STOP = STOP2;
`else
    localparam state_t FINAL_STOP = STOP;
`endif

    state_t           state_q, state_d;
    logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic             par_en_q, par_en_d;
    logic             accept_ok;
    logic             take;

    // Requests are honoured only when idle or on the last stop bit.
    always_comb begin
        accept_ok = (state_q == IDLE) || (state_q == FINAL_STOP);
        take      = Data_Valid & accept_ok;
        // Gated by RST so a request during reset never reaches the datapath.
        load      = take & RST;
    end

    // Next-state, bit counter and parity-enable capture.
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        par_en_d  = par_en_q;

        if (take) begin
            par_en_d = PAR_EN;
        end

        case (state_q)
            IDLE: begin
                if (take) begin
                    state_d = START;
                end
            end
            START: begin
                bit_cnt_d = '0;
                state_d   = DATA;
            end
            DATA: begin
                if (bit_cnt_q == LAST_BIT) begin
                    bit_cnt_d = '0;
                    state_d   = par_en_q ? PARITY : STOP;
                end else begin
                    bit_cnt_d = bit_cnt_q + CNT_W'(1);
                end
            end
            PARITY: begin
                state_d = STOP;
            end
`ifdef UART_TX_TWO_STOP_EN
            STOP: begin
                state_d = STOP2;
            end
            STOP2: begin
                state_d = take ? START : IDLE;
            end
`else
            STOP: begin
                state_d = take ? START : IDLE;
            end
`endif
            default: begin
                bit_cnt_d = '0;
                state_d   = IDLE;
            end
        endcase
    end

    // State registers; async reset forces the line high immediately.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            par_en_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            par_en_q  <= par_en_d;
        end
    end

    // Moore output decode from the current state.
    always_comb begin
        mux_sel = 2'b00;
        ser_en  = 1'b0;
        busy    = (state_q != IDLE);
        bit_cnt = bit_cnt_q;
        case (state_q)
            START:   mux_sel = 2'b01;
            DATA: begin
                mux_sel = 2'b10;
                ser_en  = 1'b1;
            end
            PARITY:  mux_sel = 2'b11;
            default: mux_sel = 2'b00;
        endcase
    end

endmodule
